// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU request arbiter: select codes, FSM states, flag bit positions.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_ADC  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_SBC  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_NOT  = 4'b0111;
    localparam logic [3:0] ALU_SHL  = 4'b1000;
    localparam logic [3:0] ALU_SHR  = 4'b1001;
    localparam logic [3:0] ALU_PASS = 4'b1010;

    // Bit positions inside the 4-bit {carry, sign, overflow, zero} flag word
    localparam int FLAG_C = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    function automatic logic [1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last granted requester.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic last_q;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Reset points at requester 1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (update) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU between two requesters, one operation in flight at a time,
// with a private carry bit kept for each requester.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       rq_valid,
    output logic [1:0]       rq_ready,
    input  logic [WIDTH-1:0] rq0_a,
    input  logic [WIDTH-1:0] rq0_b,
    input  logic [3:0]       rq0_sel,
    input  logic [WIDTH-1:0] rq1_a,
    input  logic [WIDTH-1:0] rq1_b,
    input  logic [3:0]       rq1_sel,
    output logic [1:0]       rs_valid,
    input  logic [1:0]       rs_ready,
    output logic [WIDTH-1:0] rs_data,
    output logic [3:0]       rs_flags,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_c,
    input  logic             alu_s,
    input  logic             alu_v,
    input  logic             alu_z
);

    localparam logic [2:0] CNT_LOAD = 3'(ALU_LAT - 1);

    state_t           state_q, state_d;
    logic [2:0]       cnt_q;
    logic [WIDTH-1:0] hold_a_q, hold_b_q;
    logic [3:0]       hold_sel_q;
    logic             hold_id_q;
    logic [1:0]       carry_q;
    logic [1:0]       gnt;
    logic             accept;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (rq_valid),
        .update (accept),
        .gnt    (gnt)
    );

    // rq_ready is gated by rst_n so nothing is offered while reset is held
    always_comb begin
        rq_ready = 2'b00;
        rs_valid = 2'b00;
        state_d  = state_q;
        if (rst_n && state_q == IDLE) begin
            rq_ready = gnt;
        end
        accept = |(rq_valid & rq_ready);
        case (state_q)
            IDLE: if (accept) state_d = EXEC;
            EXEC: if (cnt_q == 3'd0) state_d = CAPT;
            CAPT: state_d = RESP;
            RESP: begin
                rs_valid = id_to_onehot(hold_id_q);
                if (rs_ready[hold_id_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= 3'd0;
            hold_a_q   <= '0;
            hold_b_q   <= '0;
            hold_sel_q <= 4'd0;
            hold_id_q  <= 1'b0;
            carry_q    <= 2'b00;
            rs_data    <= '0;
            rs_flags   <= 4'd0;
        end else begin
            if (accept) begin
                hold_a_q   <= gnt[1] ? rq1_a   : rq0_a;
                hold_b_q   <= gnt[1] ? rq1_b   : rq0_b;
                hold_sel_q <= gnt[1] ? rq1_sel : rq0_sel;
                hold_id_q  <= gnt[1];
                cnt_q      <= CNT_LOAD;
            end else if (state_q == EXEC && cnt_q != 3'd0) begin
                cnt_q <= cnt_q - 3'd1;
            end
            if (state_q == CAPT) begin
                rs_data            <= alu_out;
                rs_flags[FLAG_C]   <= alu_c;
                rs_flags[FLAG_S]   <= alu_s;
                rs_flags[FLAG_V]   <= alu_v;
                rs_flags[FLAG_Z]   <= alu_z;
                carry_q[hold_id_q] <= alu_c;
            end
        end
    end

    // Holding registers stay put until the next acceptance, which keeps the ALU inputs stable
    assign alu_a   = hold_a_q;
    assign alu_b   = hold_b_q;
    assign alu_sel = hold_sel_q;
    assign alu_cin = carry_q[hold_id_q];

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: pipelined ALU model, vector table, scoreboard of responses.
module tb_alu_arbiter;
    import alu_ctrl_pkg::*;

    localparam int WIDTH   = 16;
    localparam int ALU_LAT = 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [1:0]       rq_valid, rq_ready, rs_valid, rs_ready;
    logic [WIDTH-1:0] rq0_a, rq0_b, rq1_a, rq1_b, rs_data, alu_a, alu_b, alu_out;
    logic [3:0]       rq0_sel, rq1_sel, rs_flags, alu_sel;
    logic             alu_cin, alu_c, alu_s, alu_v, alu_z;

    typedef struct {
        logic [1:0]       valid;
        logic [WIDTH-1:0] a0, b0;
        logic [3:0]       sel0;
        logic [WIDTH-1:0] a1, b1;
        logic [3:0]       sel1;
        logic             exp_gnt;
        logic             exp_cin;
        logic [WIDTH-1:0] exp_data;
        logic [3:0]       exp_flags;
    } vec_t;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] data;
        logic [3:0]       flags;
    } resp_t;

    resp_t sb_q[$];
    resp_t mon_exp;
    vec_t  vecs[12];
    int    tests_run = 0;
    int    tests_failed = 0;
    int    cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .rq_valid(rq_valid), .rq_ready(rq_ready),
        .rq0_a(rq0_a), .rq0_b(rq0_b), .rq0_sel(rq0_sel),
        .rq1_a(rq1_a), .rq1_b(rq1_b), .rq1_sel(rq1_sel),
        .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_data(rs_data), .rs_flags(rs_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_c(alu_c), .alu_s(alu_s), .alu_v(alu_v), .alu_z(alu_z)
    );

    // Result is {c, s, v, z, data}; only valid ALU_LAT edges after the operands settle
    function automatic logic [WIDTH+3:0] alu_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                   input logic [3:0] sel, input logic cin);
        logic [WIDTH:0]   wide;
        logic [WIDTH-1:0] r;
        logic             v;
        v = 1'b0;
        case (sel)
            ALU_ADD: wide = {1'b0, a} + {1'b0, b};
            ALU_ADC: wide = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            ALU_AND: wide = {1'b0, a & b};
            ALU_XOR: wide = {1'b0, a ^ b};
            default: wide = {1'b0, a};
        endcase
        r = wide[WIDTH-1:0];
        if (sel == ALU_ADD || sel == ALU_ADC)
            v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        return {wide[WIDTH], r[WIDTH-1], v, (r == '0), r};
    endfunction

    logic [WIDTH+3:0] alu_pipe [ALU_LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= alu_model(alu_a, alu_b, alu_sel, alu_cin);
        for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign {alu_c, alu_s, alu_v, alu_z, alu_out} = alu_pipe[ALU_LAT-1];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every response handshake must match the oldest accepted request
    always @(negedge clk) begin
        if (rst_n && (rs_valid & rs_ready) != 2'b00) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_response", {30'd0, rs_valid}, 32'd0);
            end else begin
                mon_exp = sb_q.pop_front();
                checkOutput("resp_route", {30'd0, rs_valid}, mon_exp.id ? 32'd2 : 32'd1);
                checkOutput("resp_data", {16'd0, rs_data}, {16'd0, mon_exp.data});
                checkOutput("resp_flags", {28'd0, rs_flags}, {28'd0, mon_exp.flags});
            end
        end
    end

    task automatic applyStimulus(input vec_t v, input bit hold, output int acc_cyc);
        bit         found;
        logic [1:0] got;
        found   = 1'b0;
        got     = 2'b00;
        acc_cyc = 0;
        rq_valid = v.valid;
        rq0_a = v.a0; rq0_b = v.b0; rq0_sel = v.sel0;
        rq1_a = v.a1; rq1_b = v.b1; rq1_sel = v.sel1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if ((rq_valid & rq_ready) != 2'b00) begin
                found = 1'b1;
                got   = rq_ready;
            end
        end
        if (!found) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            rq_valid = 2'b00;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!hold) rq_valid = 2'b00;
        checkOutput("grant", {30'd0, got}, v.exp_gnt ? 32'd2 : 32'd1);
        sb_q.push_back('{id: v.exp_gnt, data: v.exp_data, flags: v.exp_flags});
        checkOutput("alu_cin", {31'd0, alu_cin}, {31'd0, v.exp_cin});
        checkOutput("alu_a", {16'd0, alu_a}, {16'd0, v.exp_gnt ? v.a1 : v.a0});
    endtask

    // Counts edges from acceptance until rs_valid rises
    task automatic waitValid(input string name);
        int n;
        n = 0;
        while (rs_valid == 2'b00 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, n, ALU_LAT + 1);
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while (rs_valid != 2'b00 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("resp_cleared", {30'd0, rs_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        int   acc, prev, hs;
        bit   seen;

        vecs[0]  = '{2'b01, 16'h0001, 16'h0002, ALU_ADD, 16'hAAAA, 16'hAAAA, ALU_ADD, 1'b0, 1'b0, 16'h0003, 4'b0000};
        vecs[1]  = '{2'b01, 16'hFFFF, 16'h0001, ALU_ADD, 16'hAAAA, 16'hAAAA, ALU_ADD, 1'b0, 1'b0, 16'h0000, 4'b1001};
        vecs[2]  = '{2'b01, 16'h0001, 16'h0001, ALU_ADC, 16'hAAAA, 16'hAAAA, ALU_ADD, 1'b0, 1'b1, 16'h0003, 4'b0000};
        vecs[3]  = '{2'b10, 16'hAAAA, 16'hAAAA, ALU_ADD, 16'h0001, 16'h0001, ALU_ADC, 1'b1, 1'b0, 16'h0002, 4'b0000};
        vecs[4]  = '{2'b11, 16'h7FFF, 16'h0001, ALU_ADD, 16'h5555, 16'hAAAA, ALU_XOR, 1'b0, 1'b0, 16'h8000, 4'b0110};
        vecs[5]  = '{2'b11, 16'hFFFF, 16'h0000, ALU_AND, 16'h8000, 16'h8000, ALU_ADD, 1'b1, 1'b0, 16'h0000, 4'b1011};
        vecs[6]  = '{2'b10, 16'hAAAA, 16'hAAAA, ALU_ADD, 16'h0000, 16'h0000, ALU_ADC, 1'b1, 1'b1, 16'h0001, 4'b0000};
        vecs[7]  = '{2'b11, 16'hF0F0, 16'h0FF0, ALU_AND, 16'h1111, 16'h1111, ALU_ADD, 1'b0, 1'b0, 16'h00F0, 4'b0000};
        vecs[8]  = '{2'b01, 16'h1234, 16'h1234, ALU_XOR, 16'hAAAA, 16'hAAAA, ALU_ADD, 1'b0, 1'b0, 16'h0000, 4'b0001};
        vecs[9]  = '{2'b10, 16'hAAAA, 16'hAAAA, ALU_ADD, 16'hFFFF, 16'hFFFF, ALU_ADD, 1'b1, 1'b0, 16'hFFFE, 4'b1100};
        vecs[10] = '{2'b01, 16'h0000, 16'h0000, ALU_ADC, 16'hAAAA, 16'hAAAA, ALU_ADD, 1'b0, 1'b0, 16'h0000, 4'b0001};
        vecs[11] = '{2'b10, 16'hAAAA, 16'hAAAA, ALU_ADD, 16'h0000, 16'h0000, ALU_ADC, 1'b1, 1'b1, 16'h0001, 4'b0000};

        rq_valid = 2'b11;
        rs_ready = 2'b11;
        rq0_a = '0; rq0_b = '0; rq0_sel = ALU_ADD;
        rq1_a = '0; rq1_b = '0; rq1_sel = ALU_ADD;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_rq_ready", {30'd0, rq_ready}, 32'd0);
        checkOutput("reset_rs_valid", {30'd0, rs_valid}, 32'd0);
        checkOutput("reset_rs_data", {16'd0, rs_data}, 32'd0);
        checkOutput("reset_rs_flags", {28'd0, rs_flags}, 32'd0);
        checkOutput("reset_alu_a", {16'd0, alu_a}, 32'd0);
        checkOutput("reset_alu_cin", {31'd0, alu_cin}, 32'd0);
        @(negedge clk);
        rq_valid = 2'b00;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] vector table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i], 1'b0, acc);
            waitValid("latency");
            waitDone();
        end

        $display("[TB] back-to-back contention");
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            v = '{2'b11, 16'h0100, 16'h0001, ALU_ADD, 16'h0200, 16'h0002, ALU_ADD,
                  (k % 2 == 1), 1'b0, (k % 2 == 1) ? 16'h0202 : 16'h0101, 4'b0000};
            applyStimulus(v, 1'b1, acc);
            if (k > 0) checkOutput("b2b_spacing", acc - prev, ALU_LAT + 3);
            prev = acc;
        end
        rq_valid = 2'b00;
        waitValid("b2b_latency");
        waitDone();

        $display("[TB] response stall");
        rs_ready = 2'b10;
        v = '{2'b01, 16'h0005, 16'h0006, ALU_ADD, 16'hAAAA, 16'hAAAA, ALU_ADD, 1'b0, 1'b0, 16'h000B, 4'b0000};
        applyStimulus(v, 1'b0, acc);
        waitValid("stall_latency");
        rq0_a = 16'h0007; rq0_b = 16'h0000; rq0_sel = ALU_ADD;
        rq1_a = 16'h0010; rq1_b = 16'h0020; rq1_sel = ALU_ADD;
        rq_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            checkOutput("stall_valid", {30'd0, rs_valid}, 32'd1);
            checkOutput("stall_data", {16'd0, rs_data}, 32'h000B);
            checkOutput("stall_rq_ready", {30'd0, rq_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        rs_ready = 2'b11;
        @(posedge clk);
        #1;
        hs = cyc;
        checkOutput("post_handshake_rq_ready", {30'd0, rq_ready}, 32'd2);
        v = '{2'b11, 16'h0007, 16'h0000, ALU_ADD, 16'h0010, 16'h0020, ALU_ADD, 1'b1, 1'b0, 16'h0030, 4'b0000};
        applyStimulus(v, 1'b0, acc);
        checkOutput("accept_after_handshake", acc - hs, 32'd1);
        waitValid("post_stall_latency");
        waitDone();

        $display("[TB] reset during EXEC");
        v = '{2'b10, 16'hAAAA, 16'hAAAA, ALU_ADD, 16'hFFFF, 16'h0003, ALU_ADD, 1'b1, 1'b0, 16'h0002, 4'b1000};
        applyStimulus(v, 1'b0, acc);
        waitValid("carry_setup_latency");
        waitDone();
        v = '{2'b01, 16'h0001, 16'h0001, ALU_ADD, 16'hAAAA, 16'hAAAA, ALU_ADD, 1'b0, 1'b0, 16'h0002, 4'b0000};
        applyStimulus(v, 1'b0, acc);
        checkOutput("pre_reset_rs_data", {16'd0, rs_data}, 32'h0002);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        checkOutput("midop_rs_valid", {30'd0, rs_valid}, 32'd0);
        checkOutput("midop_rq_ready", {30'd0, rq_ready}, 32'd0);
        checkOutput("midop_rs_data", {16'd0, rs_data}, 32'd0);
        checkOutput("midop_rs_flags", {28'd0, rs_flags}, 32'd0);
        checkOutput("midop_alu_a", {16'd0, alu_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (rs_valid != 2'b00) seen = 1'b1;
        end
        checkOutput("no_resp_after_reset", {31'd0, seen}, 32'd0);
        v = '{2'b10, 16'hAAAA, 16'hAAAA, ALU_ADD, 16'h0000, 16'h0000, ALU_ADC, 1'b1, 1'b0, 16'h0000, 4'b0001};
        applyStimulus(v, 1'b0, acc);
        waitValid("post_reset_latency");
        waitDone();

        checkOutput("scoreboard_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
